// File: rtl/game_sequencer.sv
// Game flow controller: start / play / death pause / level-up pause / game over,
// with score, lives and level bookkeeping and mover control pulses.
//
// state       | meaning
// ------------+----------------------------------------------------------
// S_IDLE      | waiting for a start press, movers frozen
// S_PLAY      | game running, hits scored, death/goal events accepted
// S_DYING     | death pause, counts DEATH_FRAMES frames then loses a life
// S_LEVEL_UP  | level-complete pause, counts LEVEL_FRAMES frames then bonus
// S_GAME_OVER | last life lost, totals held until a start press
module game_sequencer #(
  parameter int NUMBERS      = 3,
  parameter int LIVES_INIT   = 3,
  parameter int POINTS       = 10,
  parameter int DEATH_FRAMES = 60,
  parameter int LEVEL_FRAMES = 90,
  parameter int BONUS        = 100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               start_btn,
  input  logic [NUMBERS-1:0] hit_pulse,
  input  logic               monkey_fell,
  input  logic               reached_goal,
  output logic [2:0]         game_state,
  output logic [1:0]         lives,
  output logic [13:0]        score,
  output logic [1:0]         level,
  output logic               freeze,
  output logic               respawn,
  output logic [NUMBERS-1:0] number_clear
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DYING     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_e;

  localparam logic [13:0] SCORE_MAX = 14'd9999;

  state_e             state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [13:0]        score_q, score_d;
  logic [1:0]         level_q, level_d;
  logic [7:0]         frame_q, frame_d;
  logic               freeze_q, freeze_d;
  logic               respawn_q, respawn_d;
  logic [NUMBERS-1:0] clear_q, clear_d;
  logic               start_q, start_d;
  logic               armed_q, armed_d;
  logic               start_edge;
  logic [7:0]         frame_inc;

  function automatic logic [13:0] sat_add(input logic [13:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = {18'd0, a} + b;
    return (s > 32'd9999) ? SCORE_MAX : 14'(s);
  endfunction

  function automatic logic [31:0] hit_points(input logic [NUMBERS-1:0] h);
    logic [31:0] n;
    n = '0;
    for (int i = 0; i < NUMBERS; i++) n = n + 32'(h[i]);
    return n * 32'(POINTS);
  endfunction

  // A press only counts once the button has been seen released after reset,
  // so a key held through reset cannot start a game.
  assign start_edge = start_btn & ~start_q & armed_q;
  assign start_d    = start_btn;
  assign armed_d    = armed_q | ~start_btn;
  assign frame_inc  = frame_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    level_d   = level_q;
    frame_d   = frame_q;
    respawn_d = 1'b0;
    clear_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          score_d   = '0;
          lives_d   = 2'(LIVES_INIT);
          level_d   = '0;
          respawn_d = 1'b1;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        score_d = sat_add(score_q, hit_points(hit_pulse));
        clear_d = hit_pulse;
        if (monkey_fell) begin
          state_d = S_DYING;
          frame_d = '0;
        end else if (reached_goal) begin
          state_d = S_LEVEL_UP;
          frame_d = '0;
        end
      end
      S_DYING: begin
        if (startOfFrame) begin
          frame_d = frame_inc;
          if (frame_inc == 8'(DEATH_FRAMES)) begin
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              state_d = S_GAME_OVER;
            end else begin
              state_d   = S_PLAY;
              respawn_d = 1'b1;
            end
          end
        end
      end
      S_LEVEL_UP: begin
        if (startOfFrame) begin
          frame_d = frame_inc;
          if (frame_inc == 8'(LEVEL_FRAMES)) begin
            score_d   = sat_add(score_q, 32'(BONUS));
            level_d   = (level_q == 2'd3) ? 2'd3 : level_q + 2'd1;
            respawn_d = 1'b1;
            state_d   = S_PLAY;
          end
        end
      end
      S_GAME_OVER: begin
        if (start_edge) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    freeze_d = (state_d != S_PLAY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lives_q   <= '0;
      score_q   <= '0;
      level_q   <= '0;
      frame_q   <= '0;
      freeze_q  <= 1'b1;
      respawn_q <= 1'b0;
      clear_q   <= '0;
      start_q   <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      lives_q   <= lives_d;
      score_q   <= score_d;
      level_q   <= level_d;
      frame_q   <= frame_d;
      freeze_q  <= freeze_d;
      respawn_q <= respawn_d;
      clear_q   <= clear_d;
      start_q   <= start_d;
      armed_q   <= armed_d;
    end
  end

  assign game_state   = state_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign level        = level_q;
  assign freeze       = freeze_q;
  assign respawn      = respawn_q;
  assign number_clear = clear_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed game scenarios with literal expectations,
// then random stimulus, all checked each cycle against a behavioural model.
module tb_game_sequencer;

  localparam int NUMBERS      = 3;
  localparam int LIVES_INIT   = 3;
  localparam int POINTS       = 10;
  localparam int DEATH_FRAMES = 60;
  localparam int LEVEL_FRAMES = 90;
  localparam int BONUS        = 100;

  localparam int P_IDLE = 0, P_PLAY = 1, P_DYING = 2, P_LVL = 3, P_OVER = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               startOfFrame = 1'b0;
  logic               start_btn = 1'b0;
  logic [NUMBERS-1:0] hit_pulse = '0;
  logic               monkey_fell = 1'b0;
  logic               reached_goal = 1'b0;
  logic [2:0]         game_state;
  logic [1:0]         lives;
  logic [13:0]        score;
  logic [1:0]         level;
  logic               freeze;
  logic               respawn;
  logic [NUMBERS-1:0] number_clear;

  int total = 0;
  int bad   = 0;

  game_sequencer #(
    .NUMBERS(NUMBERS), .LIVES_INIT(LIVES_INIT), .POINTS(POINTS),
    .DEATH_FRAMES(DEATH_FRAMES), .LEVEL_FRAMES(LEVEL_FRAMES), .BONUS(BONUS)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start_btn(start_btn),
    .hit_pulse(hit_pulse), .monkey_fell(monkey_fell), .reached_goal(reached_goal),
    .game_state(game_state), .lives(lives), .score(score), .level(level),
    .freeze(freeze), .respawn(respawn), .number_clear(number_clear)
  );

  always #5 clk = ~clk;

  // Behavioural model: game rules expressed on plain integers.
  int               m_phase, m_lives, m_score, m_level, m_frames, m_lim;
  bit               m_respawn, m_prev_btn, m_seen_low, m_press;
  logic [NUMBERS-1:0] m_clear;

  function automatic int cap(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = P_IDLE; m_lives = 0; m_score = 0; m_level = 0; m_frames = 0;
      m_respawn = 0; m_clear = '0; m_prev_btn = 0; m_seen_low = 0;
    end else begin
      m_press = start_btn && !m_prev_btn && m_seen_low;
      m_prev_btn = start_btn;
      if (!start_btn) m_seen_low = 1;
      m_respawn = 0;
      m_clear = '0;
      if (m_phase == P_IDLE) begin
        if (m_press) begin
          m_score = 0; m_lives = LIVES_INIT; m_level = 0;
          m_respawn = 1; m_phase = P_PLAY;
        end
      end else if (m_phase == P_PLAY) begin
        m_score = cap(m_score + $countones(hit_pulse) * POINTS);
        m_clear = hit_pulse;
        if (monkey_fell) begin m_phase = P_DYING; m_frames = 0; end
        else if (reached_goal) begin m_phase = P_LVL; m_frames = 0; end
      end else if (m_phase == P_DYING || m_phase == P_LVL) begin
        if (startOfFrame) begin
          m_frames++;
          m_lim = (m_phase == P_DYING) ? DEATH_FRAMES : LEVEL_FRAMES;
          if (m_frames == m_lim) begin
            if (m_phase == P_DYING) begin
              m_lives--;
              if (m_lives == 0) m_phase = P_OVER;
              else begin m_phase = P_PLAY; m_respawn = 1; end
            end else begin
              m_score = cap(m_score + BONUS);
              m_level = (m_level < 3) ? m_level + 1 : 3;
              m_phase = P_PLAY; m_respawn = 1;
            end
          end
        end
      end else if (m_phase == P_OVER) begin
        if (m_press) m_phase = P_IDLE;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  bit prev_resp = 0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("model.game_state", int'(game_state), m_phase);
      chk("model.lives", int'(lives), m_lives);
      chk("model.score", int'(score), m_score);
      chk("model.level", int'(level), m_level);
      chk("model.freeze", int'(freeze), (m_phase != P_PLAY) ? 1 : 0);
      chk("model.respawn", int'(respawn), int'(m_respawn));
      chk("model.number_clear", int'(number_clear), int'(m_clear));
      chk("respawn_back_to_back", int'(respawn && prev_resp), 0);
      prev_resp = respawn;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired, got t=%0t expected finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step(input bit sof_v, input logic [2:0] hit_v, input bit fell_v, input bit goal_v);
    startOfFrame = sof_v;
    hit_pulse    = hit_v;
    monkey_fell  = fell_v;
    reached_goal = goal_v;
    @(negedge clk);
  endtask

  // Frame pulses with idle cycles between; fell/goal/hits are held high to
  // show they are ignored while paused.
  task automatic pause(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 3'b111, 1'b1, 1'b1);
      step(1'b0, 3'b000, 1'b0, 1'b0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".state"}, int'(game_state), 0);
    chk({tag, ".lives"}, int'(lives), 0);
    chk({tag, ".score"}, int'(score), 0);
    chk({tag, ".level"}, int'(level), 0);
    chk({tag, ".freeze"}, int'(freeze), 1);
    chk({tag, ".respawn"}, int'(respawn), 0);
    chk({tag, ".clear"}, int'(number_clear), 0);
  endtask

  initial begin
    // reset with the start key already held
    reset = 1'b1; start_btn = 1'b1;
    @(negedge clk); @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    repeat (3) step(0, 3'b000, 0, 0);
    chk("held_btn_no_start", int'(game_state), 0);
    start_btn = 1'b0; step(0, 3'b000, 0, 0);
    start_btn = 1'b1; step(0, 3'b000, 0, 0);
    chk("start.respawn", int'(respawn), 1);
    chk("start.state", int'(game_state), 1);
    chk("start.lives", int'(lives), 3);
    chk("start.score", int'(score), 0);
    chk("start.freeze", int'(freeze), 0);
    start_btn = 1'b0; step(0, 3'b000, 0, 0);
    chk("start.respawn_drop", int'(respawn), 0);

    // hits
    step(0, 3'b101, 0, 0);
    chk("hit.score", int'(score), 20);
    chk("hit.clear", int'(number_clear), 5);
    step(0, 3'b000, 0, 0);
    chk("hit.clear_drop", int'(number_clear), 0);

    // death with both events, lives left
    step(0, 3'b000, 1, 1);
    chk("die.state", int'(game_state), 2);
    chk("die.freeze", int'(freeze), 1);
    pause(DEATH_FRAMES - 1);
    chk("die.before_end_state", int'(game_state), 2);
    chk("die.before_end_lives", int'(lives), 3);
    step(1, 3'b000, 0, 0);
    chk("die.lives", int'(lives), 2);
    chk("die.respawn", int'(respawn), 1);
    chk("die.state_play", int'(game_state), 1);
    chk("die.score_held", int'(score), 20);
    step(0, 3'b000, 0, 0);

    // two more deaths -> game over
    step(0, 3'b000, 1, 0); pause(DEATH_FRAMES);
    chk("die2.lives", int'(lives), 1);
    step(0, 3'b000, 1, 0); pause(DEATH_FRAMES);
    chk("over.state", int'(game_state), 4);
    chk("over.lives", int'(lives), 0);
    chk("over.score", int'(score), 20);
    start_btn = 1'b1; step(0, 3'b000, 0, 0);
    chk("over_to_idle.state", int'(game_state), 0);
    chk("over_to_idle.score", int'(score), 20);
    start_btn = 1'b0; step(0, 3'b000, 0, 0);

    // level up with score saturation
    start_btn = 1'b1; step(0, 3'b000, 0, 0);
    start_btn = 1'b0;
    repeat (331) step(0, 3'b111, 0, 0);
    step(0, 3'b101, 0, 0);
    chk("lvl.pre_score", int'(score), 9950);
    step(0, 3'b000, 0, 1);
    chk("lvl.state", int'(game_state), 3);
    pause(LEVEL_FRAMES - 1);
    chk("lvl.before_end_score", int'(score), 9950);
    step(1, 3'b000, 0, 0);
    chk("lvl.score_sat", int'(score), 9999);
    chk("lvl.level", int'(level), 1);
    chk("lvl.state_play", int'(game_state), 1);
    chk("lvl.respawn", int'(respawn), 1);
    step(0, 3'b111, 0, 0);
    chk("hit.score_sat", int'(score), 9999);
    for (int k = 0; k < 3; k++) begin
      step(0, 3'b000, 0, 1);
      pause(LEVEL_FRAMES);
    end
    chk("lvl.level_sat", int'(level), 3);

    // reset in the middle of a death pause
    step(0, 3'b000, 1, 0);
    pause(30);
    reset = 1'b1;
    #1;
    check_reset_vals("mid_die_reset");
    @(negedge clk);
    chk("mid_die_reset.no_respawn", int'(respawn), 0);
    reset = 1'b0;
    step(0, 3'b000, 0, 0);

    // random traffic
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 7) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 1999) == 0) begin
        reset = 1'b1;
        step(0, 3'b000, 0, 0);
        step(0, 3'b000, 0, 0);
        reset = 1'b0;
      end
      step(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 59) == 0);
    end
    step(0, 3'b000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
